// File: rtl/wb_select_stage.sv
// wb_select_stage
//   Registered write-back select stage. Picks one of NSRC result sources (or
//   CONST_VAL when sel >= NSRC), latches it with its destination address and
//   holds it for the register file over a valid/ready handshake. A selected
//   source whose BUSY_MASK bit is set and whose src_busy flag is high stalls
//   the stage in WAIT until the source is ready.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   in_valid/in_ready request handshake; sel and dst_addr sampled on accept
//   src_data/src_busy packed source values and per-source busy flags
//   out_valid/out_ready write handshake toward the register file
//   out_data/out_addr registered write value and destination
//   stall_count       saturating count of clock edges spent in WAIT
module wb_select_stage #(
  parameter int               WIDTH     = 32,
  parameter int               NSRC      = 8,
  parameter int               SELW      = 4,
  parameter int               ADDRW     = 5,
  parameter logic [WIDTH-1:0] CONST_VAL = 227,
  parameter logic [NSRC-1:0]  BUSY_MASK = 8'b0011_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic [ADDRW-1:0]      dst_addr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDRW-1:0]      out_addr,
  output logic [15:0]           stall_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [15:0]      stall_q, stall_d;
  logic             ready_w;
  logic             accept_w;

  // Loops over the sources instead of a variable part-select so selectors
  // beyond NSRC never index past the packed bus; they fall through to CONST_VAL.
  function automatic logic [WIDTH-1:0] decode_val(input logic [SELW-1:0] s,
                                                  input logic [NSRC*WIDTH-1:0] d);
    logic [WIDTH-1:0] v;
    v = CONST_VAL;
    for (int i = 0; i < NSRC; i++) begin
      if (s == SELW'(i)) v = d[i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  // Constant selection is never busy; masked-off sources ignore their flag.
  function automatic logic is_busy(input logic [SELW-1:0] s,
                                   input logic [NSRC-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (s == SELW'(i)) r = BUSY_MASK[i] & b[i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    addr_d   = addr_q;
    stall_d  = stall_q;
    ready_w  = (state_q == ST_IDLE) || ((state_q == ST_FULL) && out_ready);
    accept_w = in_valid && ready_w;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        // The edge that leaves WAIT is still an edge spent in WAIT.
        stall_d = sat_inc(stall_q);
        if (!is_busy(sel_q, src_busy)) begin
          data_d  = decode_val(sel_q, src_data);
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the FULL->IDLE drain so back-to-back writes chain.
    if (accept_w) begin
      sel_d  = sel;
      addr_d = dst_addr;
      if (is_busy(sel, src_busy)) begin
        state_d = ST_WAIT;
      end else begin
        data_d  = decode_val(sel, src_data);
        state_d = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
    end
  end

  assign in_ready    = reset && ready_w;
  assign out_valid   = (state_q == ST_FULL);
  assign out_data    = data_q;
  assign out_addr    = addr_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   sel;
  logic [4:0]   dst_addr;
  logic [255:0] src_data;
  logic [7:0]   src_busy;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [4:0]   out_addr;
  logic [15:0]  stall_count;

  int passed;
  int total;

  wb_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .dst_addr(dst_addr), .src_data(src_data), .src_busy(src_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[i*32 +: 32] = v;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    dst_addr  = '0;
    src_busy  = '0;
    src_data  = '0;
    for (int i = 0; i < 8; i++) set_src(i, pat(i));

    // Reset state
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_stall", stall_count, 0);

    @(negedge clk);
    reset = 1'b1; #1;
    chk("idle_in_ready", in_ready, 1);

    // Back-to-back sel 0..7
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sel = 4'(i); dst_addr = 5'(i + 1); #1;
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, pat(i - 1));
        chk("b2b_addr", out_addr, 5'(i));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("b2b_valid7", out_valid, 1);
    chk("b2b_data7", out_data, pat(7));
    chk("b2b_addr7", out_addr, 8);
    @(negedge clk); #1;
    chk("b2b_drain", out_valid, 0);
    chk("b2b_stall", stall_count, 0);

    // Constant selection ignores busy flags
    @(negedge clk);
    src_busy = 8'hFF; in_valid = 1'b1; sel = 4'd8; dst_addr = 5'd9;
    @(negedge clk);
    sel = 4'd15; dst_addr = 5'd10; #1;
    chk("c8_valid", out_valid, 1);
    chk("c8_data", out_data, 227);
    chk("c8_addr", out_addr, 9);
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("c15_data", out_data, 227);
    chk("c15_addr", out_addr, 10);
    chk("c15_stall", stall_count, 0);
    @(negedge clk);
    src_busy = 8'h00; #1;
    chk("c_drain", out_valid, 0);

    // Busy source 4 for three cycles, released with a new value
    @(negedge clk);
    set_src(4, 32'h1111_1111); src_busy = 8'h10;
    in_valid = 1'b1; sel = 4'd4; dst_addr = 5'd11;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("w1_ready", in_ready, 0);
    chk("w1_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b1; sel = 4'd0; #1;
    chk("w2_ready", in_ready, 0);
    chk("w2_valid", out_valid, 0);
    @(negedge clk);
    src_busy = 8'h00; set_src(4, 32'hDEAD_BEEF); out_ready = 1'b0;
    in_valid = 1'b0; #1;
    chk("w3_ready", in_ready, 0);
    chk("w3_valid", out_valid, 0);
    chk("w3_stall", stall_count, 2);
    @(negedge clk); #1;
    chk("w_out_valid", out_valid, 1);
    chk("w_out_data", out_data, 32'hDEAD_BEEF);
    chk("w_out_addr", out_addr, 11);
    chk("w_stall", stall_count, 3);

    // FULL held with out_ready low while the source keeps changing
    in_valid = 1'b1; sel = 4'd1; dst_addr = 5'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_src(4, $urandom); set_src(1, $urandom); #1;
      chk("hold_data", out_data, 32'hDEAD_BEEF);
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    @(negedge clk);
    set_src(1, 32'hCAFE_0001); out_ready = 1'b1; #1;
    chk("rel_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("rel_valid", out_valid, 1);
    chk("rel_data", out_data, 32'hCAFE_0001);
    chk("rel_addr", out_addr, 12);
    @(negedge clk); #1;
    chk("rel_drain", out_valid, 0);

    // Reset during WAIT discards the pending write
    @(negedge clk);
    src_busy = 8'h20; in_valid = 1'b1; sel = 4'd5; dst_addr = 5'd13;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("rw_enter_stall", stall_count, 3);
    @(negedge clk); #1;
    chk("rw_stall", stall_count, 4);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rw_rst_stall", stall_count, 0);
    chk("rw_rst_valid", out_valid, 0);
    chk("rw_rst_ready", in_ready, 0);
    reset = 1'b1; src_busy = 8'h00; #1;
    chk("rw_post_ready", in_ready, 1);
    @(negedge clk); #1;
    chk("rw_post_valid", out_valid, 0);
    chk("rw_post_stall", stall_count, 0);

    // Busy flag on a source whose mask bit is clear
    @(negedge clk);
    set_src(2, 32'h2222_0002); src_busy = 8'h04;
    in_valid = 1'b1; sel = 4'd2; dst_addr = 5'd14;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("m2_valid", out_valid, 1);
    chk("m2_data", out_data, 32'h2222_0002);
    chk("m2_addr", out_addr, 14);
    chk("m2_stall", stall_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
